// File: rtl/port_io_expander.sv
// Remote end of the time-multiplexed port I/O bus.
// Serves GPIO ports PORT_BASE..PORT_BASE+LOCAL_PORTS-1 of each frame.
// Direction/output writes are shadowed and committed together at frame end.
module port_io_expander #(
  parameter int unsigned BUS_PORTS   = 3,
  parameter int unsigned LOCAL_PORTS = 3,
  parameter int unsigned PORT_BASE   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     port_rst,
  inout  wire  [7:0]               data,
  input  logic [8*LOCAL_PORTS-1:0] pin_in,
  output logic [8*LOCAL_PORTS-1:0] pin_out,
  output logic [8*LOCAL_PORTS-1:0] pin_oe,
  output logic                     frame_ok,
  output logic                     frame_err,
  output logic [7:0]               err_cnt
);

  localparam int unsigned SLOTS = 3 * BUS_PORTS;
  localparam int unsigned SW    = $clog2(SLOTS + 2);
  localparam int unsigned PW    = 8 * LOCAL_PORTS;
  localparam int unsigned KW    = (LOCAL_PORTS > 1) ? $clog2(LOCAL_PORTS) : 1;

  localparam logic [1:0] ST_LOST = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [SW-1:0] slot, slot_nxt;
  logic [PW-1:0] sync1, sync2;
  logic [PW-1:0] dir_sh, out_sh;
  logic [7:0]    rd_buf;

  logic          active_c, enter_c, commit_c, abort_c, overrun_c;
  logic [SW-1:0] cur_slot_c;
  logic          dir_hit_c, rd_hit_c, wr_hit_c;
  logic [KW-1:0] dir_k_c, wr_k_c;

  // State and slot counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOST;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  // Frame tracking: sync on port_rst, commit/abort on port_rst, overrun drops to LOST
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    enter_c   = 1'b0;
    commit_c  = 1'b0;
    abort_c   = 1'b0;
    overrun_c = 1'b0;
    case (state)
      ST_LOST: begin
        if (port_rst) state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        if (!port_rst) begin
          state_nxt = ST_RUN;
          slot_nxt  = SW'(1);
          enter_c   = 1'b1;
        end
      end
      ST_RUN: begin
        if (port_rst) begin
          state_nxt = ST_SYNC;
          if (slot == SW'(SLOTS)) commit_c = 1'b1;
          else                    abort_c  = 1'b1;
        end else if (slot == SW'(SLOTS + 1)) begin
          state_nxt = ST_LOST;
          overrun_c = 1'b1;
        end else begin
          slot_nxt = slot + SW'(1);
        end
      end
      default: state_nxt = ST_LOST;
    endcase
  end

  // Slot decode; the first slot of a frame is seen while still in SYNC
  always_comb begin
    active_c   = !port_rst && ((state == ST_RUN) || (state == ST_SYNC));
    cur_slot_c = (state == ST_RUN) ? slot : '0;
    dir_hit_c  = 1'b0;
    rd_hit_c   = 1'b0;
    wr_hit_c   = 1'b0;
    dir_k_c    = '0;
    wr_k_c     = '0;
    for (int k = 0; k < LOCAL_PORTS; k++) begin
      if (cur_slot_c == SW'(3 * (PORT_BASE + k))) begin
        dir_hit_c = active_c;
        dir_k_c   = KW'(k);
      end
      if ((state == ST_RUN) && (slot == SW'(3 * (PORT_BASE + k) + 1)))
        rd_hit_c = 1'b1;
      if (cur_slot_c == SW'(3 * (PORT_BASE + k) + 2)) begin
        wr_hit_c = active_c;
        wr_k_c   = KW'(k);
      end
    end
  end

  // Bus is driven only during own READ slots, straight from rd_buf
  assign data = rd_hit_c ? rd_buf : 8'bz;

  // Two-flop synchroniser for the external pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
    end
  end

  // Shadow capture and read-back sampling; shadows restart from committed state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_sh <= '0;
      out_sh <= '0;
      rd_buf <= '0;
    end else begin
      if (enter_c || abort_c) begin
        dir_sh <= pin_oe;
        out_sh <= pin_out;
      end
      if (dir_hit_c) begin
        dir_sh[8*dir_k_c +: 8] <= data;
        rd_buf                 <= sync2[8*dir_k_c +: 8];
      end
      if (wr_hit_c) out_sh[8*wr_k_c +: 8] <= data;
    end
  end

  // Atomic pin commit, status pulses and saturating error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_oe    <= '0;
      pin_out   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_ok  <= commit_c;
      frame_err <= abort_c | overrun_c;
      if (commit_c) begin
        pin_oe  <= dir_sh;
        pin_out <= out_sh;
      end
      if ((abort_c || overrun_c) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
